// File: rtl/thermal_pkg.sv
// Shared constants and helpers for the pixel thermometer encoder/decoder pair.
//   RESOLUTION_DEF  : default pixel step per thermometer bit
//   INPUT_WIDTH_DEF : default thermometer width (= pixel width)
//   THRESHOLD       : encoder comparison offset within one step
//   clog2()         : ceil(log2(v)), usable in parameter expressions
package thermal_pkg;

    localparam int RESOLUTION_DEF  = 32;
    localparam int INPUT_WIDTH_DEF = 8;
    localparam int THRESHOLD       = RESOLUTION_DEF / 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/therm_level_count.sv
// Combinational thermometer code -> level k.
//   code_i  [W-1:0]  thermometer code, bit 0 = lowest threshold
//   level_o [KW-1:0] reconstructed level, 0..W
// Build option THERMAL_DECODER_BUBBLE_FIX_EN:
//   defined   -> k = popcount(code), tolerant of bubbles
//   undefined -> k = run of contiguous ones from bit 0
module therm_level_count
    import thermal_pkg::*;
#(
    parameter int W  = INPUT_WIDTH_DEF,
    parameter int KW = clog2(W + 1)
) (
    input  logic [W-1:0]  code_i,
    output logic [KW-1:0] level_o
);

`ifdef THERMAL_DECODER_BUBBLE_FIX_EN
    always_comb begin
        level_o = '0;
        for (int i = 0; i < W; i++) begin
            level_o = level_o + KW'(code_i[i]);
        end
    end
`else
    logic run;

    // run stays high only while every bit below (and including) i is set,
    // so bits above the first zero contribute nothing.
    always_comb begin
        level_o = '0;
        run     = 1'b1;
        for (int i = 0; i < W; i++) begin
            run     = run & code_i[i];
            level_o = level_o + KW'(run);
        end
    end
`endif

endmodule

// File: rtl/thermal_decoder.sv
// Thermometer code -> reconstructed pixel, two-stage valid/ready pipeline.
//   clk, rst_n          : clock, async active-low reset
//   therm_in/in_valid/in_ready     : upstream handshake
//   pixel_out/bubble_err/out_valid/out_ready : downstream handshake
//   err_count           : saturating count of bubbled codes entering stage 2
// Stage 1 registers the code and its bubble flag; stage 2 registers the
// saturated pixel (k*RESOLUTION clipped to all-ones).
// Build option THERMAL_DECODER_BUBBLE_FIX_EN selects the level counting
// variant (see therm_level_count).
module thermal_decoder
    import thermal_pkg::*;
#(
    parameter int RESOLUTION  = RESOLUTION_DEF,
    parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INPUT_WIDTH-1:0] therm_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [INPUT_WIDTH-1:0] pixel_out,
    output logic                   bubble_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ERR_CNT_W-1:0]   err_count
);

    localparam int KW = clog2(INPUT_WIDTH + 1);
    // Product width leaves headroom so k*RESOLUTION never wraps before clipping.
    localparam int PW = INPUT_WIDTH + clog2(RESOLUTION) + 1;
    localparam logic [INPUT_WIDTH-1:0] PIX_MAX = '1;

    // Stage 1
    logic                   s1_v_q, s1_v_d;
    logic [INPUT_WIDTH-1:0] s1_code_q, s1_code_d;
    logic                   s1_bub_q, s1_bub_d;
    // Stage 2
    logic                   s2_v_q, s2_v_d;
    logic [INPUT_WIDTH-1:0] s2_pix_q, s2_pix_d;
    logic                   s2_bub_q, s2_bub_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;

    logic                   in_fire;
    logic                   s2_open;
    logic                   s1_move;
    logic                   bub_in;
    logic [KW-1:0]          level;
    logic [PW-1:0]          prod;
    logic [INPUT_WIDTH-1:0] pix_sat;

    // s2 can take a word when empty or when its current word leaves this edge.
    assign s2_open  = !s2_v_q || out_ready;
    assign s1_move  = s1_v_q && s2_open;
    assign in_ready = !s1_v_q || !s2_v_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    // A bubble is a set bit sitting above a clear one.
    always_comb begin
        bub_in = 1'b0;
        for (int i = 1; i < INPUT_WIDTH; i++) begin
            bub_in = bub_in | (therm_in[i] & ~therm_in[i-1]);
        end
    end

    therm_level_count #(
        .W  (INPUT_WIDTH),
        .KW (KW)
    ) u_level (
        .code_i  (s1_code_q),
        .level_o (level)
    );

    assign prod    = PW'(level) * PW'(RESOLUTION);
    assign pix_sat = (prod > PW'(PIX_MAX)) ? PIX_MAX : prod[INPUT_WIDTH-1:0];

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_code_d = s1_code_q;
        s1_bub_d  = s1_bub_q;
        s2_v_d    = s2_v_q;
        s2_pix_d  = s2_pix_q;
        s2_bub_d  = s2_bub_q;
        err_d     = err_q;

        // in_ready with s1 occupied implies s1 is moving on this edge,
        // so loading s1 never overwrites an unforwarded word.
        if (in_fire) begin
            s1_v_d    = 1'b1;
            s1_code_d = therm_in;
            s1_bub_d  = bub_in;
        end else if (s1_move) begin
            s1_v_d = 1'b0;
        end

        // Data registers only change on a load, so a stalled output holds.
        if (s2_open) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_pix_d = pix_sat;
                s2_bub_d = s1_bub_q;
            end
        end

        if (s1_move && s1_bub_q && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_code_q <= '0;
            s1_bub_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_pix_q  <= '0;
            s2_bub_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_code_q <= s1_code_d;
            s1_bub_q  <= s1_bub_d;
            s2_v_q    <= s2_v_d;
            s2_pix_q  <= s2_pix_d;
            s2_bub_q  <= s2_bub_d;
            err_q     <= err_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign pixel_out  = s2_pix_q;
    assign bubble_err = s2_bub_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_thermal_decoder.sv
module tb_thermal_decoder;

    localparam int W   = 8;
    localparam int ECW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   therm_in = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   pixel_out;
    logic           bubble_err;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [ECW-1:0] err_count;

    thermal_decoder #(
        .RESOLUTION  (32),
        .INPUT_WIDTH (W),
        .ERR_CNT_W   (ECW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .therm_in   (therm_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixel_out  (pixel_out),
        .bubble_err (bubble_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [W:0] sb_q[$];
    int         pop_cyc[$];
    logic [W:0] mon_exp;

`ifdef THERMAL_DECODER_BUBBLE_FIX_EN
    localparam logic [W-1:0] EXP_0B = 8'd96;
    localparam logic [W-1:0] EXP_02 = 8'd32;
`else
    localparam logic [W-1:0] EXP_0B = 8'd64;
    localparam logic [W-1:0] EXP_02 = 8'd0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when both are high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got pixel %0d with empty scoreboard", pixel_out);
            end else begin
                mon_exp = sb_q.pop_front();
                check("pixel_out", int'(pixel_out), int'(mon_exp[W-1:0]));
                check("bubble_err", int'(bubble_err), int'(mon_exp[W]));
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Called and returns at posedge+1; word transfers on the posedge inside.
    task automatic push(input logic [W-1:0] c, input logic [W-1:0] px, input logic b);
        int n;
        n = 0;
        therm_in = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got in_ready 0 expected 1");
        end else begin
            @(posedge clk);
            sb_q.push_back({b, px});
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", int'(out_valid), 0);
        check("rst pixel_out", int'(pixel_out), 0);
        check("rst bubble_err", int'(bubble_err), 0);
        check("rst err_count", int'(err_count), 0);
        check("rst in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: latency and basic decode
        push(8'b0000_0111, 8'd96, 1'b0);
        check("t1 out_valid after accept", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("t1 out_valid next edge", int'(out_valid), 1);
        check("t1 pixel", int'(pixel_out), 96);
        drain("t1 drain");

        // 2: boundaries back-to-back
        pop_cyc.delete();
        push(8'h00, 8'd0, 1'b0);
        push(8'hFF, 8'd255, 1'b0);
        drain("t2 drain");
        if (pop_cyc.size() == 2) check("t2 consecutive", pop_cyc[1] - pop_cyc[0], 1);
        else check("t2 pop count", pop_cyc.size(), 2);

        // 3: bubbled code
        push(8'b0000_1011, EXP_0B, 1'b1);
        drain("t3 drain");
        check("t3 err_count", int'(err_count), 1);

        // 4: stall with full pipe, then release
        pop_cyc.delete();
        out_ready = 1'b0;
        push(8'h01, 8'd32, 1'b0);
        push(8'h03, 8'd64, 1'b0);
        check("t4 in_ready full", int'(in_ready), 0);
        check("t4 out_valid full", int'(out_valid), 1);
        fork
            begin
                push(8'h0F, 8'd128, 1'b0);
                push(8'h3F, 8'd192, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("t4 hold pixel", int'(pixel_out), 32);
                check("t4 in_ready held", int'(in_ready), 0);
                out_ready = 1'b1;
            end
        join
        drain("t4 drain");
        check("t4 pop count", pop_cyc.size(), 4);

        // 5: reset with two words in flight
        out_ready = 1'b0;
        push(8'b0000_1011, EXP_0B, 1'b1);
        push(8'h07, 8'd96, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 out_valid in reset", int'(out_valid), 0);
        check("t5 err_count in reset", int'(err_count), 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(8'h1F, 8'd160, 1'b0);
        drain("t5 drain");

        // 6: saturation of a 2-bit counter
        push(8'h02, EXP_02, 1'b1);
        drain("t6 drain1");
        check("t6 err_count 1", int'(err_count), 1);
        for (int i = 0; i < 4; i++) push(8'h02, EXP_02, 1'b1);
        drain("t6 drain2");
        check("t6 err_count sat", int'(err_count), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
